// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Bits needed to count 0..w, so a 1-bit adder still gets a 1-bit counter
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result valid-ready handshake bundle for the serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: single-bit combinational full adder reused every cycle by the serial adder
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with one full-adder cell and valid/ready handshakes
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    import serial_adder_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_s;
    logic             w_c;

    full_adder_cell u_fa (
        .i_a   (r_a[0]),
        .i_b   (r_b[0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_cout(w_c)
    );

    // Control FSM plus datapath shift; handshake outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.cin;
                        r_cnt      <= '0;
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sum   <= WIDTH'({w_s, r_sum} >> 1);
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_cout      <= w_c;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard-driven checks of the serial adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    task automatic test_reset();
        if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.out_ready = 0;
        if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.cin = 0; if1.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({if8.in_ready, if8.out_valid, if8.busy, if8.cout, if8.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset8: got rdy/vld/busy/cout/sum=%b_%b_%b_%b_%h want 1_0_0_0_00",
                     if8.in_ready, if8.out_valid, if8.busy, if8.cout, if8.sum);
        end
        n_vec++;
        if ({if1.in_ready, if1.out_valid, if1.busy, if1.cout, if1.sum} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset1: got rdy/vld/busy/cout/sum=%b%b%b%b%b want 10000",
                     if1.in_ready, if1.out_valid, if1.busy, if1.cout, if1.sum);
        end
        rst = 0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int hold, input bit poke, input string name);
        logic [8:0] exp;
        int n;
        int w;
        w = 0;
        while (if8.in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_vec++;
        if (if8.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s accept: in_ready=%b want 1", name, if8.in_ready);
        end
        if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1;
        if8.out_ready = (hold == 0);
        q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        @(posedge clk); #1;
        if8.in_valid = 0;
        n = 0;
        while (if8.out_valid !== 1'b1 && n <= 20) begin
            if (n == 1) begin
                n_vec++;
                if ({if8.busy, if8.in_ready} !== 2'b10) begin
                    n_err++;
                    $display("FAIL %s shift: busy/in_ready=%b%b want 10", name, if8.busy, if8.in_ready);
                end
            end
            if (poke && n == 2) begin if8.in_valid = 1; if8.a = 8'h11; end
            if (poke && n == 3) if8.in_valid = 0;
            @(posedge clk); #1; n++;
        end
        if8.in_valid = 0;
        n_vec++;
        if (n !== 8) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges want 8", name, n);
        end
        exp = q8.pop_front();
        n_vec++;
        if ({if8.cout, if8.sum} !== exp) begin
            n_err++;
            $display("FAIL %s result: got cout=%b sum=%h want cout=%b sum=%h", name, if8.cout, if8.sum, exp[8], exp[7:0]);
        end
        repeat (hold) begin
            @(posedge clk); #1;
            n_vec++;
            if ({if8.out_valid, if8.in_ready, if8.cout, if8.sum} !== {2'b10, exp}) begin
                n_err++;
                $display("FAIL %s hold: got vld=%b rdy=%b cout=%b sum=%h want 1 0 %b %h",
                         name, if8.out_valid, if8.in_ready, if8.cout, if8.sum, exp[8], exp[7:0]);
            end
        end
        if8.out_ready = 1;
        @(posedge clk); #1;
        if8.out_ready = 0;
        n_vec++;
        if ({if8.in_ready, if8.out_valid, if8.busy, if8.cout, if8.sum} !== {3'b100, exp}) begin
            n_err++;
            $display("FAIL %s handoff: got rdy/vld/busy=%b%b%b cout=%b sum=%h want 100 %b %h",
                     name, if8.in_ready, if8.out_valid, if8.busy, if8.cout, if8.sum, exp[8], exp[7:0]);
        end
    endtask

    task automatic run1(input logic a, input logic b, input logic c, input string name);
        logic [1:0] exp;
        int n;
        if1.a = a; if1.b = b; if1.cin = c; if1.in_valid = 1; if1.out_ready = 1;
        q1.push_back({1'b0, a} + {1'b0, b} + 2'(c));
        @(posedge clk); #1;
        if1.in_valid = 0;
        n = 0;
        while (if1.out_valid !== 1'b1 && n <= 20) begin
            @(posedge clk); #1; n++;
        end
        n_vec++;
        if (n !== 1) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges want 1", name, n);
        end
        exp = q1.pop_front();
        n_vec++;
        if ({if1.cout, if1.sum} !== exp) begin
            n_err++;
            $display("FAIL %s result: got cout=%b sum=%b want %b %b", name, if1.cout, if1.sum, exp[1], exp[0]);
        end
        @(posedge clk); #1;
        if1.out_ready = 0;
        n_vec++;
        if ({if1.in_ready, if1.out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL %s handoff: got rdy/vld=%b%b want 10", name, if1.in_ready, if1.out_valid);
        end
    endtask

    task automatic test_basic();
        run8(8'h5A, 8'h33, 1'b0, 0, 1'b0, "basic");
    endtask

    task automatic test_carry();
        run8(8'hFF, 8'h01, 1'b0, 0, 1'b0, "wrap");
        run8(8'hFF, 8'hFF, 1'b1, 0, 1'b0, "allones");
    endtask

    task automatic test_backpressure();
        run8(8'hA5, 8'h3C, 1'b1, 5, 1'b0, "backpressure");
    endtask

    task automatic test_ignore_in_valid();
        run8(8'h5A, 8'h33, 1'b0, 0, 1'b1, "ignore_in_valid");
    endtask

    task automatic test_reset_mid();
        int bad;
        if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 0; if8.in_valid = 1; if8.out_ready = 1;
        @(posedge clk); #1;
        if8.in_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n_vec++;
        if ({if8.in_ready, if8.out_valid, if8.busy, if8.cout, if8.sum} !== {3'b100, 9'h000}) begin
            n_err++;
            $display("FAIL reset_mid: got rdy/vld/busy=%b%b%b cout=%b sum=%h want 100 0 00",
                     if8.in_ready, if8.out_valid, if8.busy, if8.cout, if8.sum);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (if8.out_valid !== 1'b0) bad++;
        end
        if8.out_ready = 0;
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_mid_novalid: out_valid seen %0d cycles want 0", bad);
        end
        run8(8'h01, 8'h01, 1'b0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_width1();
        run1(1'b1, 1'b1, 1'b1, "w1_ones");
        run1(1'b0, 1'b0, 1'b0, "w1_zeros");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), i % 3, 1'b0, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_width1();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
